// File: rtl/i2c_target_responder_if.sv
// ----------------------------------------------------------------------------
// i2c_target_responder_if
//   Bus-side signal bundle for the I2C target responder.
//   Scl_In : SCL level as seen on the bus
//   Sda_In : resolved SDA level as seen on the bus (wired-AND of all drivers)
//   Sda_Oe : 1 = target pulls SDA low (open drain), 0 = target releases SDA
//   Modports:
//     slave  - the target responder (samples SCL/SDA, drives Sda_Oe)
//     master - the bus side / environment (supplies SCL/SDA, observes Sda_Oe)
// ----------------------------------------------------------------------------
interface i2c_target_responder_if;
    logic Scl_In;
    logic Sda_In;
    logic Sda_Oe;

    modport slave  (input Scl_In, input Sda_In, output Sda_Oe);
    modport master (output Scl_In, output Sda_In, input Sda_Oe);
endinterface

// File: rtl/i2c_target_responder.sv
// ----------------------------------------------------------------------------
// i2c_target_responder
//   I2C target (peripheral) responder. Detects START/STOP, matches a 7-bit
//   address, ACKs and captures write command bytes, and returns a multi-word
//   read payload MSB-first. SCL/SDA are oversampled by clk (clk >= 8x SCL).
//
//   Optional feature macro: I2C_TGT_CRC_EN
//     defined   - a CRC-8 byte (poly 0x31, init 0xFF, no reflection, no
//                 final xor) follows every 16-bit word; payload = 3*NUM_WORDS
//     undefined - no CRC bytes; payload = 2*NUM_WORDS; CRC logic absent
//
//   Parameters
//     TGT_ADDR    7-bit target address
//     NUM_WORDS   16-bit words per read payload (1..8)
//     SYNC_STAGES SCL/SDA synchroniser depth (>= 2)
//
//   Ports
//     clk            system clock
//     Rst_N          asynchronous active-low reset
//     bus            slave modport: Scl_In, Sda_In in; Sda_Oe out
//     Read_Data      read payload, word 0 in the MSBs
//     Command_Out    last write byte received
//     Command_Valid  one-cycle pulse when Command_Out updates
//     Bytes_Sent     bytes transmitted in the current read (incl. CRC), sat. 31
//     Busy           high from address match until STOP or master NACK
//     Nack_Seen      sticky: master NACKed before payload end; cleared by START
// ----------------------------------------------------------------------------
module i2c_target_responder #(
    parameter logic [6:0] TGT_ADDR    = 7'h44,
    parameter int         NUM_WORDS   = 2,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                      clk,
    input  logic                      Rst_N,
    i2c_target_responder_if.slave     bus,
    input  logic [16*NUM_WORDS-1:0]   Read_Data,
    output logic [7:0]                Command_Out,
    output logic                      Command_Valid,
    output logic [4:0]                Bytes_Sent,
    output logic                      Busy,
    output logic                      Nack_Seen
);

`ifdef I2C_TGT_CRC_EN
    localparam int BYTES_PER_WORD = 3;
`else
    localparam int BYTES_PER_WORD = 2;
`endif
    localparam int         PAYLOAD_LEN = BYTES_PER_WORD * NUM_WORDS;
    localparam logic [4:0] PAYLOAD_LIM = 5'(PAYLOAD_LEN);
    localparam logic [3:0] WORD_LIMIT  = 4'(NUM_WORDS);
    localparam logic [1:0] LAST_POS    = 2'(BYTES_PER_WORD - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        ADDR_ACK,
        WR_DATA,
        WR_ACK,
        RD_DATA,
        RD_ACK,
        WAIT_STOP
    } state_t;

    // Bytes_Sent counts up but never wraps.
    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

`ifdef I2C_TGT_CRC_EN
    // One MSB-first step of CRC-8, polynomial x^8 + x^5 + x^4 + 1 (0x31).
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return fb ? ({crc[6:0], 1'b0} ^ 8'h31) : {crc[6:0], 1'b0};
    endfunction
`endif

    // ---------------- input synchroniser and edge detection ----------------
    // Flops reset to 1 so a reset never fabricates a START/STOP or SCL edge.
    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_prev;
    logic                   sda_prev;

    always_ff @(posedge clk or negedge Rst_N) begin
        if (!Rst_N) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_prev <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], bus.Scl_In};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], bus.Sda_In};
            scl_prev <= scl_sync[SYNC_STAGES-1];
            sda_prev <= sda_sync[SYNC_STAGES-1];
        end
    end

    logic scl_s, sda_s;
    logic scl_rise, scl_fall, scl_held_high;
    logic start_det, stop_det;

    assign scl_s         = scl_sync[SYNC_STAGES-1];
    assign sda_s         = sda_sync[SYNC_STAGES-1];
    assign scl_rise      =  scl_s & ~scl_prev;
    assign scl_fall      = ~scl_s &  scl_prev;
    // START/STOP need SCL high on both samples, so an SCL edge in the same
    // clock as an SDA edge is treated as a clock edge, never a condition.
    assign scl_held_high =  scl_s &  scl_prev;
    assign start_det     = scl_held_high &  sda_prev & ~sda_s;
    assign stop_det      = scl_held_high & ~sda_prev &  sda_s;

    // ---------------- state ----------------
    state_t                  state_q, state_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic                    sda_oe_q, sda_oe_d;
    logic                    rw_q, rw_d;
    logic                    busy_q, busy_d;
    logic                    nack_q, nack_d;
    logic [4:0]              sent_q, sent_d;
    logic [7:0]              cmd_q, cmd_d;
    logic                    cmd_vld_q, cmd_vld_d;

    logic [6:0]              shift_q, shift_d;
    logic [7:0]              tx_q, tx_d;
    logic [16*NUM_WORDS-1:0] snap_q, snap_d;
    logic [3:0]              word_idx_q, word_idx_d;
    logic [1:0]              byte_pos_q, byte_pos_d;
`ifdef I2C_TGT_CRC_EN
    logic [7:0]              crc_q, crc_d;
`endif

    assign bus.Sda_Oe    = sda_oe_q;
    assign Command_Out   = cmd_q;
    assign Command_Valid = cmd_vld_q;
    assign Bytes_Sent    = sent_q;
    assign Busy          = busy_q;
    assign Nack_Seen     = nack_q;

    // ---------------- payload byte selection ----------------
    // word_idx/byte_pos point at the next byte to load into tx; anything past
    // the payload end reads as 8'hFF (SDA left released).
    logic [15:0] cur_word;
    logic [7:0]  next_byte;

    always_comb begin
        cur_word = 16'h0000;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (word_idx_q == 4'(i)) begin
                cur_word = snap_q[16*(NUM_WORDS-1-i) +: 16];
            end
        end
    end

    always_comb begin
        next_byte = 8'hFF;
        if (word_idx_q < WORD_LIMIT) begin
            case (byte_pos_q)
                2'd0:    next_byte = cur_word[15:8];
                2'd1:    next_byte = cur_word[7:0];
`ifdef I2C_TGT_CRC_EN
                default: next_byte = crc_q;
`else
                default: next_byte = 8'hFF;
`endif
            endcase
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        sda_oe_d   = sda_oe_q;
        rw_d       = rw_q;
        busy_d     = busy_q;
        nack_d     = nack_q;
        sent_d     = sent_q;
        cmd_d      = cmd_q;
        cmd_vld_d  = 1'b0;
        shift_d    = shift_q;
        tx_d       = tx_q;
        snap_d     = snap_q;
        word_idx_d = word_idx_q;
        byte_pos_d = byte_pos_q;
`ifdef I2C_TGT_CRC_EN
        crc_d      = crc_q;
`endif

        if (start_det) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            nack_d    = 1'b0;
            sent_d    = 5'd0;
        end else if (stop_det) begin
            state_d   = IDLE;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                end

                ADDR: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[5:0], sda_s};
                        if (bit_cnt_q == 4'd7) begin
                            // shift_q holds address bits 7..1, sda_s is R/W.
                            if (shift_q == TGT_ADDR) begin
                                state_d    = ADDR_ACK;
                                bit_cnt_d  = 4'd8;
                                busy_d     = 1'b1;
                                rw_d       = sda_s;
                                word_idx_d = 4'd0;
                                byte_pos_d = 2'd0;
`ifdef I2C_TGT_CRC_EN
                                crc_d      = 8'hFF;
`endif
                                if (sda_s) begin
                                    snap_d = Read_Data;
                                    sent_d = 5'd0;
                                end
                            end else begin
                                state_d = WAIT_STOP;
                                busy_d  = 1'b0;
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end

                // bit_cnt 8: waiting for the 8th falling edge to assert ACK;
                // bit_cnt 9: ACK is on the bus until the 9th falling edge.
                ADDR_ACK, WR_ACK: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d  = 1'b1;
                            bit_cnt_d = 4'd9;
                        end else begin
                            bit_cnt_d = 4'd0;
                            if (state_q == ADDR_ACK && rw_q) begin
                                tx_d     = next_byte;
                                sda_oe_d = ~next_byte[7];
                                state_d  = RD_DATA;
                            end else begin
                                sda_oe_d = 1'b0;
                                state_d  = WR_DATA;
                            end
                        end
                    end
                end

                WR_DATA: begin
                    if (scl_rise) begin
                        shift_d = {shift_q[5:0], sda_s};
                        if (bit_cnt_q == 4'd7) begin
                            cmd_d     = {shift_q, sda_s};
                            cmd_vld_d = 1'b1;
                            state_d   = WR_ACK;
                            bit_cnt_d = 4'd8;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end

                // Each falling edge retires the bit in tx_q[7] and presents
                // the next one; the 8th releases SDA for the master's ACK.
                RD_DATA: begin
                    if (scl_fall) begin
`ifdef I2C_TGT_CRC_EN
                        if (byte_pos_q != 2'd2 && word_idx_q < WORD_LIMIT) begin
                            crc_d = crc8_step(crc_q, tx_q[7]);
                        end
`endif
                        tx_d = {tx_q[6:0], 1'b1};
                        if (bit_cnt_q == 4'd7) begin
                            sda_oe_d  = 1'b0;
                            sent_d    = sat_inc(sent_q);
                            state_d   = RD_ACK;
                            bit_cnt_d = 4'd8;
                            if (word_idx_q < WORD_LIMIT) begin
                                if (byte_pos_q == LAST_POS) begin
                                    byte_pos_d = 2'd0;
                                    word_idx_d = word_idx_q + 4'd1;
`ifdef I2C_TGT_CRC_EN
                                    crc_d      = 8'hFF;
`endif
                                end else begin
                                    byte_pos_d = byte_pos_q + 2'd1;
                                end
                            end
                        end else begin
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            sda_oe_d  = ~tx_q[6];
                        end
                    end
                end

                RD_ACK: begin
                    if (scl_rise && bit_cnt_q == 4'd8) begin
                        if (!sda_s) begin
                            bit_cnt_d = 4'd9;
                        end else begin
                            state_d = WAIT_STOP;
                            busy_d  = 1'b0;
                            if (sent_q < PAYLOAD_LIM) begin
                                nack_d = 1'b1;
                            end
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd9) begin
                        tx_d      = next_byte;
                        sda_oe_d  = ~next_byte[7];
                        bit_cnt_d = 4'd0;
                        state_d   = RD_DATA;
                    end
                end

                WAIT_STOP: begin
                end

                default: begin
                    state_d  = IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // ---------------- control registers ----------------
    always_ff @(posedge clk or negedge Rst_N) begin
        if (!Rst_N) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            sda_oe_q  <= 1'b0;
            rw_q      <= 1'b0;
            busy_q    <= 1'b0;
            nack_q    <= 1'b0;
            sent_q    <= 5'd0;
            cmd_q     <= 8'h00;
            cmd_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            sda_oe_q  <= sda_oe_d;
            rw_q      <= rw_d;
            busy_q    <= busy_d;
            nack_q    <= nack_d;
            sent_q    <= sent_d;
            cmd_q     <= cmd_d;
            cmd_vld_q <= cmd_vld_d;
        end
    end

    // ---------------- datapath registers ----------------
    // Only read after being loaded by an address match, so no reset needed.
    always_ff @(posedge clk) begin
        shift_q    <= shift_d;
        tx_q       <= tx_d;
        snap_q     <= snap_d;
        word_idx_q <= word_idx_d;
        byte_pos_q <= byte_pos_d;
`ifdef I2C_TGT_CRC_EN
        crc_q      <= crc_d;
`endif
    end

endmodule

// File: tb/tb_i2c_target_responder.sv
// ----------------------------------------------------------------------------
// tb_i2c_target_responder
//   Bench for i2c_target_responder. A bit-banged I2C master drives SCL/SDA;
//   read bytes, ACKs and status outputs are compared against a payload model
//   built from Read_Data with plain arithmetic, and a per-cycle monitor
//   checks Command_Valid/Command_Out against the queue of expected commands
//   and that the target leaves SDA alone when it must.
// ----------------------------------------------------------------------------
module tb_i2c_target_responder;
    localparam logic [6:0] TGT = 7'h44;
    localparam int NW = 2;
`ifdef I2C_TGT_CRC_EN
    localparam int BPW = 3;
`else
    localparam int BPW = 2;
`endif
    localparam int PLEN = BPW * NW;
    localparam int Q    = 5;   // quarter SCL period in clk cycles

    logic        clk       = 1'b0;
    logic        rst_n     = 1'b0;
    logic        scl_m     = 1'b1;
    logic        sda_m     = 1'b1;
    logic [31:0] read_data = 32'h0;
    logic [7:0]  command_out;
    logic        command_valid;
    logic [4:0]  bytes_sent;
    logic        busy;
    logic        nack_seen;

    int          errors = 0;
    int          checks = 0;
    logic        quiet  = 1'b1;
    logic [7:0]  cmd_q[$];
    logic        oe_prev  = 1'b0;
    logic        rst_prev = 1'b0;
    logic [7:0]  wbuf [0:3];
    logic [7:0]  rbuf [0:39];

    i2c_target_responder_if bus();
    assign bus.Scl_In = scl_m;
    assign bus.Sda_In = sda_m & ~bus.Sda_Oe;

    i2c_target_responder #(
        .TGT_ADDR   (TGT),
        .NUM_WORDS  (NW),
        .SYNC_STAGES(2)
    ) dut (
        .clk          (clk),
        .Rst_N        (rst_n),
        .bus          (bus),
        .Read_Data    (read_data),
        .Command_Out  (command_out),
        .Command_Valid(command_valid),
        .Bytes_Sent   (bytes_sent),
        .Busy         (busy),
        .Nack_Seen    (nack_seen)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic [7:0] crc8(input logic [15:0] w);
        logic [7:0] c;
        c = 8'hFF;
        for (int b = 0; b < 2; b++) begin
            c = c ^ (b == 0 ? w[15:8] : w[7:0]);
            for (int i = 0; i < 8; i++) begin
                c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
            end
        end
        return c;
    endfunction

    function automatic logic [7:0] exp_byte(input logic [31:0] data, input int k);
        int          w;
        int          p;
        logic [15:0] word;
        if (k >= PLEN) return 8'hFF;
        w    = k / BPW;
        p    = k % BPW;
        word = data[16*(NW-1-w) +: 16];
        if (p == 0) return word[15:8];
        if (p == 1) return word[7:0];
        return crc8(word);
    endfunction

    // ---------------- per-cycle monitor ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("oe_in_reset", 32'(bus.Sda_Oe), 32'd0);
        end else begin
            if (quiet) chk("oe_quiet", 32'(bus.Sda_Oe), 32'd0);
            if (command_valid) begin
                if (cmd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL command_valid_unexpected: got pulse with Command_Out=%02h, required no pulse", command_out);
                end else begin
                    chk("command_out_on_valid", 32'(command_out), 32'(cmd_q.pop_front()));
                end
            end
            if (rst_prev && scl_m && (bus.Sda_Oe !== oe_prev)) begin
                checks++;
                errors++;
                $display("FAIL oe_edge_timing: Sda_Oe changed to %0b while SCL high, required change only while SCL low", bus.Sda_Oe);
            end
        end
        oe_prev  = bus.Sda_Oe;
        rst_prev = rst_n;
    end

    // ---------------- bit-banged master ----------------
    task automatic wt(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic m_start();
        if (scl_m) begin
            sda_m = 1'b1; wt(Q);
            sda_m = 1'b0; wt(Q);
            scl_m = 1'b0; wt(2);
        end else begin
            sda_m = 1'b1; wt(Q);
            scl_m = 1'b1; wt(Q);
            sda_m = 1'b0; wt(Q);
            scl_m = 1'b0; wt(2);
        end
    endtask

    task automatic m_stop();
        sda_m = 1'b0; wt(Q);
        scl_m = 1'b1; wt(Q);
        sda_m = 1'b1; wt(2*Q);
    endtask

    task automatic m_bit(input logic b, output logic r);
        wt(Q); sda_m = b;
        wt(Q); scl_m = 1'b1;
        wt(Q); r = bus.Sda_In;
        wt(Q); scl_m = 1'b0;
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) m_bit(d[i], r);
        m_bit(1'b1, r);
        ack = ~r;
    endtask

    task automatic read_byte(input logic ack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            m_bit(1'b1, r);
            d[i] = r;
        end
        m_bit(ack ? 1'b0 : 1'b1, r);
    endtask

    // ---------------- transactions ----------------
    task automatic do_write(input logic [6:0] addr, input int n);
        logic ack;
        logic match;
        match = (addr == TGT);
        m_start();
        chk("nack_cleared_on_start", 32'(nack_seen), 32'd0);
        if (match) quiet = 1'b0;
        write_byte({addr, 1'b0}, ack);
        chk("write_addr_ack", 32'(ack), 32'(match));
        chk("busy_after_write_addr", 32'(busy), 32'(match));
        for (int i = 0; i < n; i++) begin
            if (match) cmd_q.push_back(wbuf[i]);
            write_byte(wbuf[i], ack);
            chk("write_data_ack", 32'(ack), 32'(match));
        end
        m_stop();
        quiet = 1'b1;
        chk("busy_after_stop", 32'(busy), 32'd0);
        chk("command_pulses_outstanding", 32'(cmd_q.size()), 32'd0);
    endtask

    task automatic do_read(input logic [31:0] data, input int n, input logic change_mid,
                           input logic [31:0] new_data, input logic keep_bus);
        logic       ack;
        logic [7:0] d;
        read_data = data;
        m_start();
        chk("nack_cleared_on_start", 32'(nack_seen), 32'd0);
        quiet = 1'b0;
        write_byte({TGT, 1'b1}, ack);
        chk("read_addr_ack", 32'(ack), 32'd1);
        chk("busy_after_read_addr", 32'(busy), 32'd1);
        if (change_mid) read_data = new_data;
        for (int k = 0; k < n; k++) begin
            read_byte(k < n - 1, d);
            rbuf[k] = d;
            chk("read_byte", 32'(d), 32'(exp_byte(data, k)));
        end
        chk("bytes_sent", 32'(bytes_sent), (n > 31) ? 32'd31 : 32'(n));
        chk("nack_seen", 32'(nack_seen), 32'(n < PLEN));
        chk("busy_after_nack", 32'(busy), 32'd0);
        if (!keep_bus) begin
            m_stop();
            quiet = 1'b1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] d32;
        logic [6:0]  a7;
        logic        ack;
        logic        r;
        int          n;

        wt(3);
        chk("reset_sda_oe", 32'(bus.Sda_Oe), 32'd0);
        chk("reset_command_out", 32'(command_out), 32'h00);
        chk("reset_command_valid", 32'(command_valid), 32'd0);
        chk("reset_bytes_sent", 32'(bytes_sent), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_nack_seen", 32'(nack_seen), 32'd0);
        rst_n = 1'b1;
        wt(5);

        // matched write of one command byte
        wbuf[0] = 8'hFD;
        do_write(TGT, 1);
        chk("command_out_fd", 32'(command_out), 32'hFD);

        // neighbouring address must be ignored
        wbuf[0] = 8'(($urandom));
        do_write(7'h45, 1);
        chk("command_out_unchanged", 32'(command_out), 32'hFD);

        // known payload pinned to literal bytes
`ifdef I2C_TGT_CRC_EN
        do_read(32'hBEEF_6666, 6, 1'b0, 32'h0, 1'b0);
        chk("lit_b0", 32'(rbuf[0]), 32'hBE);
        chk("lit_b1", 32'(rbuf[1]), 32'hEF);
        chk("lit_b2", 32'(rbuf[2]), 32'h92);
        chk("lit_b3", 32'(rbuf[3]), 32'h66);
        chk("lit_b4", 32'(rbuf[4]), 32'h66);
        chk("lit_b5", 32'(rbuf[5]), 32'h93);
        chk("lit_bytes_sent", 32'(bytes_sent), 32'd6);
        chk("lit_nack_seen", 32'(nack_seen), 32'd0);
`else
        do_read(32'hBEEF_6666, 2, 1'b0, 32'h0, 1'b0);
        chk("lit_b0", 32'(rbuf[0]), 32'hBE);
        chk("lit_b1", 32'(rbuf[1]), 32'hEF);
        chk("lit_bytes_sent", 32'(bytes_sent), 32'd2);
        chk("lit_nack_seen", 32'(nack_seen), 32'd1);
`endif

        // snapshot: change Read_Data mid-read, then repeated START + read
        do_read(32'h1234_A5C3, PLEN, 1'b1, 32'h0F0F_7E81, 1'b1);
        do_read(32'h0F0F_7E81, PLEN, 1'b0, 32'h0, 1'b0);

        // master keeps ACKing long past the payload: FF filler, count saturates
        do_read(32'hCAFE_0123, 33, 1'b0, 32'h0, 1'b0);

        // randomized mix
        for (int it = 0; it < 14; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    n = $urandom_range(1, 4);
                    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
                    do_write(TGT, n);
                end
                1: begin
                    a7 = 7'($urandom);
                    if (a7 == TGT) a7 = a7 ^ 7'h01;
                    n = $urandom_range(0, 2);
                    for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom);
                    do_write(a7, n);
                end
                default: begin
                    d32 = $urandom;
                    n   = $urandom_range(1, PLEN + 2);
                    do_read(d32, n, 1'($urandom_range(0, 1)), $urandom, 1'b0);
                end
            endcase
        end

        // reset while the target is pulling SDA low during a read bit
        read_data = 32'h0000_0000;
        m_start();
        quiet = 1'b0;
        write_byte({TGT, 1'b1}, ack);
        chk("rst_test_addr_ack", 32'(ack), 32'd1);
        for (int i = 0; i < 3; i++) m_bit(1'b1, r);
        wt(Q); sda_m = 1'b1;
        wt(Q); scl_m = 1'b1;
        wt(2);
        chk("oe_before_reset", 32'(bus.Sda_Oe), 32'd1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("oe_released_by_async_reset", 32'(bus.Sda_Oe), 32'd0);
        chk("busy_in_reset", 32'(busy), 32'd0);
        chk("bytes_sent_in_reset", 32'(bytes_sent), 32'd0);
        wt(3);
        rst_n = 1'b1;
        quiet = 1'b1;
        wt(Q); scl_m = 1'b0;
        wt(Q);
        m_stop();
        wbuf[0] = 8'h5A;
        wbuf[1] = 8'hC3;
        do_write(TGT, 2);
        chk("command_out_after_reset", 32'(command_out), 32'hC3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
